// File: rtl/stopwatch_core_mux.sv
// Stopwatch core: tick divider, run/lap/pause FSM, BCD counter, display scanner.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the top nonzero digit.
module stopwatch_core_mux #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              lap,
  input  logic              add,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              running,
  output logic              overflow
);

  localparam int CW = DIGITS * 4;
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_PAUSE
  } state_e;

  state_e state_q, state_d;

  logic [3:0]        btn_q;
  logic [3:0]        pulse;
  logic              ev_start, ev_stop, ev_lap, ev_add;

  logic [TW-1:0]     tdiv_q, tdiv_d;
  logic              tick;

  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     snap_q, snap_d;
  logic              ovf_q, ovf_d;
  logic [CW:0]       inc_v;
  logic              inc;

  logic [SW-1:0]     sdiv_q, sdiv_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic [CW-1:0]     src;
  logic [3:0]        digit;
  logic [DIGITS-1:0] blank;

  function automatic logic [CW:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Button order in the history register: {add, lap, stop, start}
  assign pulse = {add, lap, stop, start} & ~btn_q;

  // Only the highest-priority pulse acts, even if it is a no-op here
  assign ev_stop  = pulse[1];
  assign ev_start = pulse[0] & ~pulse[1];
  assign ev_lap   = pulse[2] & ~pulse[1] & ~pulse[0];
  assign ev_add   = pulse[3] & ~pulse[2] & ~pulse[1] & ~pulse[0];

  assign running = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick    = running && (tdiv_q == TW'(TICK_DIV - 1));
  assign inc_v   = bcd_inc(count_q);

  always_comb begin
    tdiv_d = tdiv_q;
    if (state_q == S_IDLE) begin
      tdiv_d = '0;
    end else if (running) begin
      tdiv_d = tick ? '0 : tdiv_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    snap_d  = snap_q;
    ovf_d   = ovf_q;
    inc     = tick;
    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (ev_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (ev_stop) begin
          state_d = S_PAUSE;
        end else if (ev_lap) begin
          state_d = S_LAP;
          snap_d  = count_q;
        end
      end
      S_LAP: begin
        if (ev_stop)     state_d = S_PAUSE;
        else if (ev_lap) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (ev_start) begin
          state_d = S_RUN;
        end else if (ev_lap) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (ev_add) begin
          inc = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (inc) begin
      count_d = inc_v[CW-1:0];
      if (inc_v[CW]) ovf_d = 1'b1;
    end
  end

  assign src   = (state_q == S_LAP) ? snap_q : count_q;
  assign digit = src[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic seen;
    seen  = 1'b0;
    blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (src[i*4 +: 4] != 4'd0) seen = 1'b1;
      blank[i] = ~seen;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    sdiv_d = sdiv_q + 1'b1;
    idx_d  = idx_q;
    if (sdiv_q == SW'(SCAN_DIV - 1)) begin
      sdiv_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    // an and seg both come from idx_q so they switch on the same edge
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = blank[idx_q] ? 7'h7F : seg_dec(digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      btn_q   <= '0;
      tdiv_q  <= '0;
      count_q <= '0;
      snap_q  <= '0;
      ovf_q   <= 1'b0;
      sdiv_q  <= '0;
      idx_q   <= '0;
      an_q    <= ~DIGITS'(1);
      seg_q   <= 7'b1000000;
    end else begin
      state_q <= state_d;
      btn_q   <= {add, lap, stop, start};
      tdiv_q  <= tdiv_d;
      count_q <= count_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
      sdiv_q  <= sdiv_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign overflow = ovf_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_stopwatch_core_mux.sv
// Bench for stopwatch_core_mux with DIGITS=4, TICK_DIV=4, SCAN_DIV=2.
// Expected counts and display patterns are queued, then popped on observation.
module tb_stopwatch_core_mux;

  logic       clk = 1'b0;
  logic       rst, start, stop, lap, add;
  logic [6:0] seg;
  logic [3:0] an;
  logic       running, overflow;

  int n_vec = 0;
  int n_bad = 0;
  int ecnt  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] e;

  stopwatch_core_mux #(
    .DIGITS(4),
    .TICK_DIV(4),
    .SCAN_DIV(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .lap(lap),
    .add(add),
    .seg(seg),
    .an(an),
    .running(running),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic wait_edge(input int n);
    while (ecnt < n) @(negedge clk);
  endtask

  // mask = {add, lap, stop, start}; e_s is the sampling edge number
  task automatic press(input logic [3:0] m, output int e_s);
    {add, lap, stop, start} = m;
    e_s = ecnt + 1;
    @(negedge clk);
    {add, lap, stop, start} = 4'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); n_vec++;
    if (dut.count_q !== e) begin
      n_bad++; $display("FAIL reset_count got %h want %h", dut.count_q, e);
    end
    n_vec++;
    if ({running, overflow} !== 2'b00) begin
      n_bad++; $display("FAIL reset_flags got %b want 00", {running, overflow});
    end
    n_vec++;
    if ({an, seg} !== {4'b1110, 7'b1000000}) begin
      n_bad++; $display("FAIL reset_disp got %b/%b want 1110/1000000", an, seg);
    end
  endtask

  task automatic test_run_reset();
    int p;
    do_reset();
    press(4'b0001, p);
    exp_q.push_back(16'h0010);
    wait_edge(p + 40);
    e = exp_q.pop_front(); n_vec++;
    if (dut.count_q !== e) begin
      n_bad++; $display("FAIL run40_count got %h want %h", dut.count_q, e);
    end
    n_vec++;
    if (running !== 1'b1) begin
      n_bad++; $display("FAIL run40_running got %b want 1", running);
    end
    step(3);
    do_reset();
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); n_vec++;
    if (dut.count_q !== e) begin
      n_bad++; $display("FAIL midrst_count got %h want %h", dut.count_q, e);
    end
    n_vec++;
    if ({running, an, seg} !== {1'b0, 4'b1110, 7'b1000000}) begin
      n_bad++; $display("FAIL midrst_disp got %b/%b/%b want 0/1110/1000000", running, an, seg);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_lap();
    int p, l, s, hits;
    bit found;
    do_reset();
    press(4'b0001, p);
    exp_q.push_back(16'h0008);
    wait_edge(p + 32);
    e = exp_q.pop_front(); n_vec++;
    if (dut.count_q !== e) begin
      n_bad++; $display("FAIL lap_pre_count got %h want %h", dut.count_q, e);
    end
    press(4'b0100, l);
    hits = 0;
    while (ecnt < p + 52) begin
      @(negedge clk);
      if (an === 4'b1110) begin
        hits++; n_vec++;
        if (seg !== seg_of(4'd8)) begin
          n_bad++; $display("FAIL lap_snap_seg got %b want %b", seg, seg_of(4'd8));
        end
      end
    end
    n_vec++;
    if (hits == 0) begin
      n_bad++; $display("FAIL lap_snap_timeout got 0 want >0 digit0 slots");
    end
    exp_q.push_back(16'h0013);
    e = exp_q.pop_front(); n_vec++;
    if ({running, dut.count_q} !== {1'b1, e}) begin
      n_bad++; $display("FAIL lap_live got %b/%h want 1/%h", running, dut.count_q, e);
    end
    press(4'b0100, l);
    press(4'b0010, s);
    exp_q.push_back(16'h0013);
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      if (an === 4'b1110) begin
        found = 1'b1; n_vec++;
        if (seg !== seg_of(4'd3)) begin
          n_bad++; $display("FAIL lap_back_seg got %b want %b", seg, seg_of(4'd3));
        end
      end
    end
    n_vec++;
    if (!found) begin
      n_bad++; $display("FAIL lap_back_timeout got none want digit0 slot");
    end
    e = exp_q.pop_front(); n_vec++;
    if (dut.count_q !== e) begin
      n_bad++; $display("FAIL lap_back_count got %h want %h", dut.count_q, e);
    end
  endtask

  task automatic test_add();
    int p, s, x;
    do_reset();
    press(4'b0001, p);
    wait_edge(p + 11);
    press(4'b0010, x);
    exp_q.push_back(16'h0003);
    e = exp_q.pop_front(); n_vec++;
    if ({running, dut.count_q} !== {1'b0, e}) begin
      n_bad++; $display("FAIL stop_tick got %b/%h want 0/%h", running, dut.count_q, e);
    end
    press(4'b1000, x);
    press(4'b1000, x);
    exp_q.push_back(16'h0005);
    e = exp_q.pop_front(); n_vec++;
    if (dut.count_q !== e) begin
      n_bad++; $display("FAIL add2_count got %h want %h", dut.count_q, e);
    end
    press(4'b0001, s);
    press(4'b1000, x);
    exp_q.push_back(16'h0005);
    exp_q.push_back(16'h0006);
    e = exp_q.pop_front(); n_vec++;
    if (dut.count_q !== e) begin
      n_bad++; $display("FAIL add_ignored got %h want %h", dut.count_q, e);
    end
    wait_edge(s + 4);
    e = exp_q.pop_front(); n_vec++;
    if ({running, dut.count_q} !== {1'b1, e}) begin
      n_bad++; $display("FAIL add_resume got %b/%h want 1/%h", running, dut.count_q, e);
    end
  endtask

  task automatic test_overflow();
    int p, s, x;
    do_reset();
    press(4'b0001, p);
    press(4'b0010, x);
    repeat (9999) press(4'b1000, x);
    exp_q.push_back(16'h9999);
    e = exp_q.pop_front(); n_vec++;
    if ({overflow, dut.count_q} !== {1'b0, e}) begin
      n_bad++; $display("FAIL preload got %b/%h want 0/%h", overflow, dut.count_q, e);
    end
    press(4'b0001, s);
    exp_q.push_back(16'h9999);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    e = exp_q.pop_front(); n_vec++;
    if (dut.count_q !== e) begin
      n_bad++; $display("FAIL pre_wrap got %h want %h", dut.count_q, e);
    end
    wait_edge(s + 2);
    e = exp_q.pop_front(); n_vec++;
    if ({overflow, dut.count_q} !== {1'b1, e}) begin
      n_bad++; $display("FAIL wrap got %b/%h want 1/%h", overflow, dut.count_q, e);
    end
    wait_edge(s + 6);
    e = exp_q.pop_front(); n_vec++;
    if ({overflow, dut.count_q} !== {1'b1, e}) begin
      n_bad++; $display("FAIL sticky got %b/%h want 1/%h", overflow, dut.count_q, e);
    end
    press(4'b0010, x);
    press(4'b0100, x);
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); n_vec++;
    if ({running, overflow, dut.count_q} !== {2'b01, e}) begin
      n_bad++; $display("FAIL pause_lap got %b%b/%h want 01/%h", running, overflow, dut.count_q, e);
    end
    do_reset();
    n_vec++;
    if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL ovf_reset got %b want 0", overflow);
    end
  endtask

  task automatic test_simul();
    int x;
    do_reset();
    press(4'b0011, x);
    step(10);
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); n_vec++;
    if ({running, dut.count_q} !== {1'b0, e}) begin
      n_bad++; $display("FAIL idle_startstop got %b/%h want 0/%h", running, dut.count_q, e);
    end
    press(4'b0001, x);
    press(4'b0010, x);
    n_vec++;
    if (running !== 1'b0) begin
      n_bad++; $display("FAIL simul_pause got %b want 0", running);
    end
    press(4'b0101, x);
    n_vec++;
    if (running !== 1'b1) begin
      n_bad++; $display("FAIL pause_startlap got %b want 1", running);
    end
  endtask

  task automatic test_scan();
    logic [15:0] a;
    do_reset();
    exp_q.push_back(16'hE); exp_q.push_back(16'hE);
    exp_q.push_back(16'hD); exp_q.push_back(16'hD);
    exp_q.push_back(16'hB); exp_q.push_back(16'hB);
    exp_q.push_back(16'h7); exp_q.push_back(16'h7);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = {12'h0, an};
      e = exp_q.pop_front(); n_vec++;
      if (a !== e) begin
        n_bad++; $display("FAIL scan_an[%0d] got %b want %b", i, an, e[3:0]);
      end
    end
  endtask

  task automatic test_blank();
    int x, idx;
    logic [15:0] model;
    logic [6:0]  want;
    do_reset();
    press(4'b0001, x);
    press(4'b0010, x);
    repeat (42) press(4'b1000, x);
    model = 16'h0042;
    exp_q.push_back(model);
    e = exp_q.pop_front(); n_vec++;
    if (dut.count_q !== e) begin
      n_bad++; $display("FAIL blank_count got %h want %h", dut.count_q, e);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idx = -1;
      for (int k = 0; k < 4; k++) if (an == ~(4'b1 << k)) idx = k;
      n_vec++;
      if (idx < 0) begin
        n_bad++; $display("FAIL blank_an got %b want one-hot-low", an);
      end else begin
        want = seg_of(model[idx*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx >= 2) want = 7'h7F;
`endif
        exp_q.push_back({9'h0, want});
        e = exp_q.pop_front(); n_vec++;
        if ({9'h0, seg} !== e) begin
          n_bad++; $display("FAIL blank_seg[%0d] got %b want %b", idx, seg, e[6:0]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; lap = 1'b0; add = 1'b0;
    @(negedge clk);
    test_reset();
    test_run_reset();
    test_lap();
    test_add();
    test_overflow();
    test_simul();
    test_scan();
    test_blank();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
